sram_sp_init: RTL and testbench
===============================

Name: sram_sp_init

Overview:
- Parametrised single-port synchronous RAM for predictor tables (BHT/BTB/tag arrays).
- Adds three things to a plain RAM:
  - a hardware clear sweep after reset and on demand (flush);
  - write masks at a configurable granularity;
  - a read-data-valid handshake.
- Behavioural storage array; synthesisable and Verilator-clean.
- Sits between the BPU control logic and the table storage.

Parameters:
- WIDTH, 39, data bits per entry.
- DEPTH, 256, number of entries; any value ≥2, need not be a power of two.
- GRAN, 39, bits per write-mask lane; WIDTH must be a multiple of GRAN.
- INIT_VALUE, 0, WIDTH-bit value written to every entry by the clear sweep.
- Derived: ADDR_W = $clog2(DEPTH); MASK_W = WIDTH/GRAN.

Ports:
- clk, input, 1, sole clock; all logic on the rising edge.
- rst, input, 1, synchronous active-high reset.
- flush, input, 1, request a full clear sweep.
- ready, output, 1, high when requests are accepted (not sweeping).
- req_valid, input, 1, request strobe.
- we, input, 1, 1 = write, 0 = read; sampled with req_valid.
- addr, input, ADDR_W, entry index.
- wmask, input, MASK_W, per-lane write enable; lane i covers bits [i*GRAN +: GRAN].
- din, input, WIDTH, write data.
- rdata, output, WIDTH, read/write-first data.
- rdata_valid, output, 1, one-cycle pulse marking new rdata.

Behaviour:
- Interface: clock is clk; reset is rst, synchronous, active-high.
- FSM states: INIT (sweep) and READY.
- Reset:
  - while rst=1: state=INIT, sweep counter=0, ready=0, rdata=0, rdata_valid=0;
  - memory contents are not cleared by rst itself, only by the sweep.
- INIT:
  - each cycle writes INIT_VALUE to entry[counter], then counter++;
  - after writing entry DEPTH-1, state goes to READY next cycle;
  - ready rises exactly DEPTH cycles after rst deasserts;
  - ready=0 throughout INIT.
- Accept condition: a request is accepted iff req_valid & ready & ~flush. Requests offered while ready=0 are ignored, with no side effects. The requester holds the request until ready.
- Write (we=1):
  - only lanes with wmask[i]=1 are updated; other lanes keep their old value;
  - wmask=0 is a legal no-op write.
- Latency 1: the cycle after an accepted request, rdata_valid=1 and rdata is driven:
  - read: rdata = entry[addr];
  - write (write-first): rdata = post-write merged entry.
- rdata holds its last value when there is no accepted request; rdata_valid=0 in those cycles.
- Back-to-back requests are accepted every cycle, with full throughput.
- A read of an address written the previous cycle returns the new data.
- Out-of-range addr (addr ≥ DEPTH, non-power-of-two DEPTH only):
  - writes have no effect;
  - reads return rdata=0, still with rdata_valid=1.
- flush:
  - from READY: the same-cycle request is dropped; next cycle state=INIT with counter=0;
  - a response for a request accepted in the previous cycle is still delivered;
  - flush during INIT restarts the counter at 0;
  - rst has priority over flush.
- rst asserted mid-sweep or mid-request: any pending rdata_valid is cancelled and the sweep restarts after release.

Optional Feature:
- Macro: SRAM_OUTREG_EN.
- When defined:
  - adds an output pipeline register, making read latency 2;
  - rdata_valid is delayed accordingly;
  - flush does not cancel in-flight responses;
  - rst clears both stages to 0.
- When undefined: latency 1 as above.

Decomposition:
- Shared package sram_pkg:
  - state enum (INIT, READY);
  - function computing ADDR_W/MASK_W;
  - localparam for default BPU geometry (39x256).
- Sub-module sram_sp_core:
  - pure storage array with masked write, write-first read, and 1-cycle registered rdata;
  - the top level owns the FSM, sweep counter, accept logic and the optional output register.

Test Plan:
- Reset sweep:
  - stimulus: DEPTH=256, INIT_VALUE=39'h5A5A; release rst; then read addr 0, 128 and 255;
  - required: ready rises exactly 256 cycles after release; each read returns 39'h5A5A with rdata_valid one cycle later.
- Masked write (WIDTH=32, GRAN=8):
  - stimulus: write 32'hFFFFFFFF, mask 4'hF, to addr 7; then write 32'h12345678, mask 4'b0101, to addr 7;
  - required: write-first rdata = 32'hFF34FF78; a subsequent read also returns 32'hFF34FF78.
- Back-to-back:
  - stimulus: write addr 3 = 0x1 at cycle N; read addr 3 at cycle N+1;
  - required: rdata_valid high at N+1 and N+2; rdata = 0x1 at both.
- Flush mid-traffic:
  - stimulus: assert flush together with a write to addr 9;
  - required: the write is dropped; ready=0 for 256 cycles; addr 9 then reads INIT_VALUE.
- Request while not ready:
  - stimulus: req_valid=1, we=1 during the sweep;
  - required: no rdata_valid pulse; memory unchanged.
- Non-power-of-two geometry:
  - stimulus: DEPTH=100; write to addr 120; read addr 120;
  - required: rdata=0 with rdata_valid=1; entries 0..99 unchanged.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared definitions for the single-port predictor-table RAM.
//   - sram_state_e : sweep / ready controller states
//   - addr_w()     : address width for a given entry count (min 1 bit)
//   - mask_w()     : number of write-mask lanes for a WIDTH/GRAN pair
//   - BPU_WIDTH/BPU_DEPTH : default BPU table geometry (39 x 256)
package sram_pkg;

  typedef enum logic {
    ST_INIT,
    ST_READY
  } sram_state_e;

  localparam int unsigned BPU_WIDTH = 39;
  localparam int unsigned BPU_DEPTH = 256;

  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int unsigned mask_w(input int unsigned width, input int unsigned gran);
    return width / gran;
  endfunction

endpackage

// File: rtl/sram_sp_init_if.sv
// Request/response bus between BPU control logic and sram_sp_init.
//   master (BPU side) : drives flush, req_valid, we, addr, wmask, din
//                       samples ready, rdata, rdata_valid
//   slave  (RAM side) : the reverse
interface sram_sp_init_if
  import sram_pkg::*;
#(
  parameter int unsigned WIDTH = BPU_WIDTH,
  parameter int unsigned DEPTH = BPU_DEPTH,
  parameter int unsigned GRAN  = BPU_WIDTH
);

  localparam int unsigned ADDR_W = addr_w(DEPTH);
  localparam int unsigned MASK_W = mask_w(WIDTH, GRAN);

  logic              flush;
  logic              ready;
  logic              req_valid;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [MASK_W-1:0] wmask;
  logic [WIDTH-1:0]  din;
  logic [WIDTH-1:0]  rdata;
  logic              rdata_valid;

  modport master (
    output flush, req_valid, we, addr, wmask, din,
    input  ready, rdata, rdata_valid
  );

  modport slave (
    input  flush, req_valid, we, addr, wmask, din,
    output ready, rdata, rdata_valid
  );

endinterface

// File: rtl/sram_sp_core.sv
// Storage array for sram_sp_init: masked write, write-first read,
// one-cycle registered read data.
//   clk      : clock (rising edge)
//   i_rst    : synchronous active-high clear of the read-data register
//   i_we     : write the merged entry at i_addr
//   i_cap    : load o_rdata with the (write-first) entry at i_addr
//   i_addr   : entry index; indices >= DEPTH are ignored and read as 0
//   i_wmask  : per-lane write enable, lane l = bits [l*GRAN +: GRAN]
//   i_din    : write data
//   o_rdata  : registered read data
module sram_sp_core #(
  parameter int unsigned WIDTH  = 39,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned GRAN   = 39,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned MASK_W = 1
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic              i_cap,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [MASK_W-1:0] i_wmask,
  input  logic [WIDTH-1:0]  i_din,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;
  logic [WIDTH-1:0] w_old;
  logic [WIDTH-1:0] w_merged;
  logic             w_in_range;

  // Power-of-two depths cover the whole address space, so no compare is needed.
  generate
    if (DEPTH == (1 << ADDR_W)) begin : g_full
      assign w_in_range = 1'b1;
    end else begin : g_partial
      assign w_in_range = (32'(i_addr) < DEPTH);
    end
  endgenerate

  always_comb begin
    w_old = '0;
    if (w_in_range) begin
      w_old = r_mem[i_addr];
    end
  end

  always_comb begin
    w_merged = w_old;
    for (int unsigned l = 0; l < MASK_W; l++) begin
      if (i_wmask[l]) begin
        w_merged[l*GRAN +: GRAN] = i_din[l*GRAN +: GRAN];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_we && w_in_range) begin
      r_mem[i_addr] <= w_merged;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_rdata <= '0;
    end else if (i_cap) begin
      if (!w_in_range) begin
        r_rdata <= '0;
      end else if (i_we) begin
        r_rdata <= w_merged;
      end else begin
        r_rdata <= w_old;
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sram_sp_init.sv
// Single-port predictor-table RAM with hardware clear sweep, lane write
// masks and a read-data-valid pulse.
//   clk  : clock (rising edge)
//   rst  : synchronous active-high reset; restarts the clear sweep
//   bus  : sram_sp_init_if.slave (flush, ready, req_valid, we, addr,
//          wmask, din, rdata, rdata_valid)
// After reset or flush every entry is written with INIT_VALUE, one per
// cycle; ready stays low for DEPTH cycles. Accepted requests answer one
// cycle later with rdata_valid.
// Optional macro SRAM_OUTREG_EN: extra output register, read latency 2.
module sram_sp_init
  import sram_pkg::*;
#(
  parameter int unsigned      WIDTH      = BPU_WIDTH,
  parameter int unsigned      DEPTH      = BPU_DEPTH,
  parameter int unsigned      GRAN       = BPU_WIDTH,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
  input logic          clk,
  input logic          rst,
  sram_sp_init_if.slave bus
);

  localparam int unsigned      ADDR_W = addr_w(DEPTH);
  localparam int unsigned      MASK_W = mask_w(WIDTH, GRAN);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  sram_state_e       r_state;
  sram_state_e       w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;
  logic              w_ready;
  logic              w_accept;
  logic              r_rvalid;

  logic              w_we;
  logic              w_cap;
  logic [ADDR_W-1:0] w_addr;
  logic [MASK_W-1:0] w_wmask;
  logic [WIDTH-1:0]  w_din;
  logic [WIDTH-1:0]  w_core_rdata;

  // ready is masked by rst so it drops in the very cycle reset is asserted.
  assign w_ready  = (r_state == ST_READY) && !rst;
  assign w_accept = bus.req_valid && w_ready && !bus.flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_we        = 1'b0;
    w_cap       = 1'b0;
    w_addr      = bus.addr;
    w_wmask     = bus.wmask;
    w_din       = bus.din;
    case (r_state)
      ST_INIT: begin
        if (!rst) begin
          w_we    = 1'b1;
          w_addr  = r_cnt;
          w_wmask = '1;
          w_din   = INIT_VALUE;
        end
        if (bus.flush) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == LAST) begin
          w_state_nxt = ST_READY;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + ADDR_W'(1);
        end
      end
      ST_READY: begin
        if (w_accept) begin
          w_we  = bus.we;
          w_cap = 1'b1;
        end
        if (bus.flush) begin
          w_state_nxt = ST_INIT;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_INIT;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_accept;
    end
  end

  sram_sp_core #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .GRAN   (GRAN),
    .ADDR_W (ADDR_W),
    .MASK_W (MASK_W)
  ) u_core (
    .clk     (clk),
    .i_rst   (rst),
    .i_we    (w_we),
    .i_cap   (w_cap),
    .i_addr  (w_addr),
    .i_wmask (w_wmask),
    .i_din   (w_din),
    .o_rdata (w_core_rdata)
  );

  assign bus.ready = w_ready;

`ifdef SRAM_OUTREG_EN
  logic [WIDTH-1:0] r_rdata_q;
  logic             r_rvalid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata_q  <= '0;
      r_rvalid_q <= 1'b0;
    end else begin
      r_rvalid_q <= r_rvalid;
      if (r_rvalid) begin
        r_rdata_q <= w_core_rdata;
      end
    end
  end

  assign bus.rdata       = r_rdata_q;
  assign bus.rdata_valid = r_rvalid_q;
`else
  assign bus.rdata       = w_core_rdata;
  assign bus.rdata_valid = r_rvalid;
`endif

endmodule

// File: tb/tb_sram_sp_init.sv
// Directed bench for sram_sp_init (default build, read latency 1).
// DUT A: 39 x 256, one mask lane, INIT_VALUE 39'h5A5A.
// DUT B: 32 x 100, four 8-bit lanes, INIT_VALUE 32'hCAFE0001.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_sram_sp_init;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  localparam logic [38:0] A_INIT = 39'h5A5A;
  localparam logic [31:0] B_INIT = 32'hCAFE0001;

  sram_sp_init_if #(.WIDTH(39), .DEPTH(256), .GRAN(39)) bus_a ();
  sram_sp_init_if #(.WIDTH(32), .DEPTH(100), .GRAN(8))  bus_b ();

  sram_sp_init #(
    .WIDTH      (39),
    .DEPTH      (256),
    .GRAN       (39),
    .INIT_VALUE (A_INIT)
  ) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  sram_sp_init #(
    .WIDTH      (32),
    .DEPTH      (100),
    .GRAN       (8),
    .INIT_VALUE (B_INIT)
  ) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic a_set(input logic v, input logic w, input logic [7:0] ad, input logic [38:0] d);
    bus_a.req_valid = v;
    bus_a.we        = w;
    bus_a.addr      = ad;
    bus_a.wmask     = 1'b1;
    bus_a.din       = d;
  endtask

  task automatic b_set(input logic v, input logic w, input logic [6:0] ad,
                       input logic [3:0] m, input logic [31:0] d);
    bus_b.req_valid = v;
    bus_b.we        = w;
    bus_b.addr      = ad;
    bus_b.wmask     = m;
    bus_b.din       = d;
  endtask

  task automatic a_txn(input string tag, input logic w, input logic [7:0] ad,
                       input logic [38:0] d, input logic [38:0] exp);
    @(negedge clk);
    a_set(1'b1, w, ad, d);
    @(negedge clk);
    a_set(1'b0, 1'b0, 8'd0, '0);
    check({tag, ".valid"}, 64'(bus_a.rdata_valid), 64'd1);
    check({tag, ".rdata"}, 64'(bus_a.rdata), 64'(exp));
  endtask

  task automatic b_txn(input string tag, input logic w, input logic [6:0] ad,
                       input logic [3:0] m, input logic [31:0] d,
                       input bit chk_data, input logic [31:0] exp);
    @(negedge clk);
    b_set(1'b1, w, ad, m, d);
    @(negedge clk);
    b_set(1'b0, 1'b0, 7'd0, 4'h0, '0);
    check({tag, ".valid"}, 64'(bus_b.rdata_valid), 64'd1);
    if (chk_data) begin
      check({tag, ".rdata"}, 64'(bus_b.rdata), 64'(exp));
    end
  endtask

  // Counts falling edges until ready is seen; 0 means it never rose in the budget.
  task automatic wait_ready_a(output int n);
    n = 0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (bus_a.ready) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_ready_b(output int n);
    n = 0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (bus_b.ready) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ta;
    int tb;
    int pulses;
    int n;

    bus_a.flush = 1'b0;
    bus_b.flush = 1'b0;
    a_set(1'b0, 1'b0, 8'd0, '0);
    b_set(1'b0, 1'b0, 7'd0, 4'h0, '0);

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_a.ready", 64'(bus_a.ready), 64'd0);
    check("rst_a.valid", 64'(bus_a.rdata_valid), 64'd0);
    check("rst_a.rdata", 64'(bus_a.rdata), 64'd0);
    check("rst_b.ready", 64'(bus_b.ready), 64'd0);
    check("rst_b.rdata", 64'(bus_b.rdata), 64'd0);

    // Release reset; offer a write to A while it is sweeping (must be ignored).
    rst = 1'b0;
    a_set(1'b1, 1'b1, 8'd5, '1);
    ta = 0;
    tb = 0;
    pulses = 0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (bus_a.rdata_valid) pulses++;
      if (i == 200) a_set(1'b0, 1'b0, 8'd0, '0);
      if (bus_a.ready && ta == 0) ta = i;
      if (bus_b.ready && tb == 0) tb = i;
      if (ta != 0 && tb != 0) break;
    end
    check("sweep_a.cycles", 64'(ta), 64'd256);
    check("sweep_b.cycles", 64'(tb), 64'd100);
    check("busy_req.pulses", 64'(pulses), 64'd0);

    // Swept contents, including the entry targeted while not ready.
    a_txn("a_rd0",   1'b0, 8'd0,   '0, A_INIT);
    a_txn("a_rd128", 1'b0, 8'd128, '0, A_INIT);
    a_txn("a_rd255", 1'b0, 8'd255, '0, A_INIT);
    a_txn("a_rd5",   1'b0, 8'd5,   '0, A_INIT);

    // Back-to-back write then read of the same entry.
    @(negedge clk);
    a_set(1'b1, 1'b1, 8'd3, 39'h1);
    @(negedge clk);
    check("b2b_wr.valid", 64'(bus_a.rdata_valid), 64'd1);
    check("b2b_wr.rdata", 64'(bus_a.rdata), 64'd1);
    a_set(1'b1, 1'b0, 8'd3, '0);
    @(negedge clk);
    check("b2b_rd.valid", 64'(bus_a.rdata_valid), 64'd1);
    check("b2b_rd.rdata", 64'(bus_a.rdata), 64'd1);
    a_set(1'b0, 1'b0, 8'd0, '0);
    @(negedge clk);
    check("idle.valid", 64'(bus_a.rdata_valid), 64'd0);
    check("idle.hold",  64'(bus_a.rdata), 64'd1);

    // Flush together with a write: prior response still seen, write dropped.
    @(negedge clk);
    a_set(1'b1, 1'b1, 8'd9, 39'h12_3456_789A);
    @(negedge clk);
    check("pre_flush.valid", 64'(bus_a.rdata_valid), 64'd1);
    check("pre_flush.rdata", 64'(bus_a.rdata), 64'h12_3456_789A);
    bus_a.flush = 1'b1;
    a_set(1'b1, 1'b1, 8'd9, 39'h55_5555_5555);
    @(negedge clk);
    bus_a.flush = 1'b0;
    a_set(1'b0, 1'b0, 8'd0, '0);
    check("flush.ready", 64'(bus_a.ready), 64'd0);
    check("flush.drop",  64'(bus_a.rdata_valid), 64'd0);
    wait_ready_a(n);
    check("flush_a.cycles", 64'(n), 64'd256);
    a_txn("a_rd9", 1'b0, 8'd9, '0, A_INIT);

    // Masked writes on B.
    b_txn("b_rd99",  1'b0, 7'd99, 4'h0, '0, 1'b1, B_INIT);
    b_txn("b_wr_ff", 1'b1, 7'd7, 4'hF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF);
    b_txn("b_wr_m5", 1'b1, 7'd7, 4'b0101, 32'h1234_5678, 1'b1, 32'hFF34_FF78);
    b_txn("b_rd7",   1'b0, 7'd7, 4'h0, '0, 1'b1, 32'hFF34_FF78);
    b_txn("b_wr_m0", 1'b1, 7'd7, 4'h0, 32'h0000_0000, 1'b1, 32'hFF34_FF78);
    b_txn("b_rd7b",  1'b0, 7'd7, 4'h0, '0, 1'b1, 32'hFF34_FF78);

    // Out-of-range address on non-power-of-two depth.
    b_txn("b_wr120", 1'b1, 7'd120, 4'hF, 32'hDEAD_BEEF, 1'b0, '0);
    b_txn("b_rd120", 1'b0, 7'd120, 4'h0, '0, 1'b1, 32'h0);
    b_txn("b_rd20",  1'b0, 7'd20, 4'h0, '0, 1'b1, B_INIT);
    b_txn("b_rd99b", 1'b0, 7'd99, 4'h0, '0, 1'b1, B_INIT);
    b_txn("b_rd0",   1'b0, 7'd0,  4'h0, '0, 1'b1, B_INIT);

    // Flush during the sweep restarts it from entry 0.
    @(negedge clk);
    bus_b.flush = 1'b1;
    @(negedge clk);
    bus_b.flush = 1'b0;
    repeat (49) @(negedge clk);
    check("b_midsweep.ready", 64'(bus_b.ready), 64'd0);
    bus_b.flush = 1'b1;
    @(negedge clk);
    bus_b.flush = 1'b0;
    wait_ready_b(n);
    check("reflush_b.cycles", 64'(n), 64'd100);
    b_txn("b_rd7c", 1'b0, 7'd7, 4'h0, '0, 1'b1, B_INIT);

    // Reset together with a request: no response, rdata cleared, sweep restarts.
    @(negedge clk);
    rst = 1'b1;
    a_set(1'b1, 1'b0, 8'd0, '0);
    @(negedge clk);
    check("rst_req.valid", 64'(bus_a.rdata_valid), 64'd0);
    check("rst_req.rdata", 64'(bus_a.rdata), 64'd0);
    check("rst_req.ready", 64'(bus_a.ready), 64'd0);
    a_set(1'b0, 1'b0, 8'd0, '0);
    rst = 1'b0;
    wait_ready_a(n);
    check("sweep_a2.cycles", 64'(n), 64'd256);
    a_txn("a_rd3", 1'b0, 8'd3, '0, A_INIT);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
